// File: rtl/ts_ctrl_avg.sv
// ts_ctrl_avg: temperature-sensor controller with chopped averaging.
//   Drives the analog TS timing (enable, start pulse, conversion clock,
//   chopper phase), captures ADC samples on the synchronised DETOK edge,
//   averages 2^(AVG_LOG2+1) samples, then adds a signed trim and saturates.
// Ports:
//   clk, RSTn            clock, async active-low reset
//   meas_en, single_shot measurement enable (level) / one-shot mode
//   FLOCK, reg_ts_en_sel D2A_TS_EN source select
//   reg_offset           signed trim added to the mean
//   A2D_TS_DETOK/DOUT    conversion done (async) / result
//   D2A_TS_*             analog control outputs (registered except EN)
//   ts_out/ts_valid      averaged result and one-clk update strobe
//   ts_err               sticky conversion timeout flag
module ts_ctrl_avg #(
   parameter int DW            = 8,
   parameter int OFS_W         = 4,
   parameter int CLK_DIV       = 25,
   parameter int AVG_LOG2      = 1,
   parameter int TIMEOUT_TICKS = 40
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic             meas_en,
   input  logic             single_shot,
   input  logic             FLOCK,
   input  logic             reg_ts_en_sel,
   input  logic [OFS_W-1:0] reg_offset,
   input  logic             A2D_TS_DETOK,
   input  logic [DW-1:0]    A2D_TS_DOUT,
   output logic             D2A_TS_EN,
   output logic             D2A_TS_START_EN,
   output logic             D2A_TS_CLK,
   output logic             D2A_TS_CHOPPER_CLK,
   output logic [DW-1:0]    ts_out,
   output logic             ts_valid,
   output logic             ts_err
);

   localparam int NS  = 1 << (AVG_LOG2 + 1);
   localparam int AW  = DW + AVG_LOG2 + 1;
   localparam int CW  = AVG_LOG2 + 2;
   localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW  = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [2:0] {IDLE, START, CONV, ACC, DONE} state_t;

   state_t          state_q;
   logic [DVW-1:0]  div_q;
   logic [TW-1:0]   tmo_q;
   logic [AW-1:0]   acc_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   cap_q, ts_out_q;
   logic            chop_q, start_en_q, tsclk_q, ts_valid_q, ts_err_q, meas_en_q;
   logic [2:0]      detok_q;   // [1:0] synchroniser, [2] edge history

   logic            det_edge, tick, meas_rise;
   logic [DW-1:0]   mean, res;
   logic signed [DW+1:0] sum_d;

   assign det_edge  = detok_q[1] & ~detok_q[2];
   assign tick      = (div_q == DVW'(CLK_DIV - 1));
   assign meas_rise = meas_en & ~meas_en_q;

   // Mean plus sign-extended trim, clamped to the DW-bit unsigned range.
   always_comb begin
      mean  = DW'(acc_q >> (AVG_LOG2 + 1));
      sum_d = $signed({2'b00, mean}) +
              $signed({{(DW + 2 - OFS_W){reg_offset[OFS_W-1]}}, reg_offset});
      if (sum_d[DW+1])   res = '0;
      else if (sum_d[DW]) res = '1;
      else               res = sum_d[DW-1:0];
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= IDLE;
         div_q      <= '0;
         tmo_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         cap_q      <= '0;
         ts_out_q   <= '0;
         chop_q     <= 1'b0;
         start_en_q <= 1'b0;
         tsclk_q    <= 1'b0;
         ts_valid_q <= 1'b0;
         ts_err_q   <= 1'b0;
         meas_en_q  <= 1'b0;
         detok_q    <= '0;
      end else begin
         detok_q    <= {detok_q[1:0], A2D_TS_DETOK};
         meas_en_q  <= meas_en;
         ts_valid_q <= 1'b0;
         div_q      <= tick ? '0 : div_q + 1'b1;

         // Losing meas_en mid-measurement abandons the frame; DONE still
         // completes so a finished average is never thrown away.
         if (!meas_en && state_q != IDLE && state_q != DONE) begin
            state_q    <= IDLE;
            start_en_q <= 1'b0;
            tsclk_q    <= 1'b0;
            chop_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (meas_rise) ts_err_q <= 1'b0;
                  if (single_shot ? meas_rise : meas_en) begin
                     state_q    <= START;
                     start_en_q <= 1'b1;
                     div_q      <= '0;
                  end
               end
               START: begin
                  // div restarted on entry, so the first tick ends the pulse
                  if (tick) begin
                     state_q    <= CONV;
                     start_en_q <= 1'b0;
                     tmo_q      <= '0;
                  end
               end
               CONV: begin
                  if (det_edge) begin
                     cap_q   <= A2D_TS_DOUT;
                     state_q <= ACC;
                  end else if (tick) begin
                     if (tmo_q == TW'(TIMEOUT_TICKS - 1)) begin
                        // retry the same frame: chopper and count untouched
                        ts_err_q   <= 1'b1;
                        tsclk_q    <= 1'b0;
                        state_q    <= START;
                        start_en_q <= 1'b1;
                        div_q      <= '0;
                     end else begin
                        tmo_q   <= tmo_q + 1'b1;
                        tsclk_q <= ~tsclk_q;
                     end
                  end
               end
               ACC: begin
                  acc_q   <= acc_q + AW'(cap_q);
                  cnt_q   <= cnt_q + 1'b1;
                  chop_q  <= ~chop_q;
                  tsclk_q <= 1'b0;
                  if (cnt_q == CW'(NS - 1)) begin
                     state_q <= DONE;
                  end else begin
                     state_q    <= START;
                     start_en_q <= 1'b1;
                     div_q      <= '0;
                  end
               end
               DONE: begin
                  ts_out_q   <= res;
                  ts_valid_q <= 1'b1;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  chop_q     <= 1'b0;
                  if (!single_shot && meas_en) begin
                     state_q    <= START;
                     start_en_q <= 1'b1;
                     div_q      <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign D2A_TS_EN          = reg_ts_en_sel ? FLOCK : 1'b1;
   assign D2A_TS_START_EN    = start_en_q;
   assign D2A_TS_CLK         = tsclk_q;
   assign D2A_TS_CHOPPER_CLK = chop_q;
   assign ts_out             = ts_out_q;
   assign ts_valid           = ts_valid_q;
   assign ts_err             = ts_err_q;

endmodule

// File: tb/tb_ts_ctrl_avg.sv
`timescale 1ns/1ps
module tb_ts_ctrl_avg;
   localparam int DW = 8, OFS_W = 4, CLK_DIV = 25, AVG_LOG2 = 1, TIMEOUT_TICKS = 40;
   localparam int NS = 1 << (AVG_LOG2 + 1);

   logic clk = 0, RSTn = 0, meas_en = 0, single_shot = 0, FLOCK = 0, reg_ts_en_sel = 0;
   logic [OFS_W-1:0] reg_offset = '0;
   logic A2D_TS_DETOK = 0;
   logic [DW-1:0] A2D_TS_DOUT = '0;
   logic D2A_TS_EN, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid, ts_err;
   logic [DW-1:0] ts_out;

   ts_ctrl_avg #(.DW(DW), .OFS_W(OFS_W), .CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2),
                 .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
      .clk(clk), .RSTn(RSTn), .meas_en(meas_en), .single_shot(single_shot),
      .FLOCK(FLOCK), .reg_ts_en_sel(reg_ts_en_sel), .reg_offset(reg_offset),
      .A2D_TS_DETOK(A2D_TS_DETOK), .A2D_TS_DOUT(A2D_TS_DOUT),
      .D2A_TS_EN(D2A_TS_EN), .D2A_TS_START_EN(D2A_TS_START_EN), .D2A_TS_CLK(D2A_TS_CLK),
      .D2A_TS_CHOPPER_CLK(D2A_TS_CHOPPER_CLK), .ts_out(ts_out), .ts_valid(ts_valid),
      .ts_err(ts_err));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int gen = 0, frame_no = 0, drop_frame = -1, exp_out = 0;
   int plan_q[$], samp_q[$], sen_q[$];
   logic chop_q[$];

   // Reference: mean of the accepted samples plus trim, clamped to DW bits.
   function automatic int model(input int s[$], input int off);
      int sum, r;
      sum = 0;
      foreach (s[i]) sum += s[i];
      r = sum / NS + off;
      if (r < 0) r = 0;
      if (r > (1 << DW) - 1) r = (1 << DW) - 1;
      return r;
   endfunction

   // Analog sensor behaviour: answer each conversion after a random delay.
   initial begin : responder
      int g, f, dly, d;
      forever begin
         @(negedge D2A_TS_START_EN);
         if (RSTn) begin
            g = gen; f = frame_no; frame_no++;
            if (f != drop_frame) begin
               dly = $urandom_range(2 * CLK_DIV, 5 * CLK_DIV);
               repeat (dly) @(posedge clk);
               #2;
               if (g == gen) begin
                  d = (plan_q.size() > 0) ? plan_q.pop_front() : int'($urandom_range(0, 255));
                  A2D_TS_DOUT = DW'(d);
                  A2D_TS_DETOK = 1;
                  samp_q.push_back(d);
                  chop_q.push_back(D2A_TS_CHOPPER_CLK);
                  repeat (5) @(posedge clk);
                  #2 A2D_TS_DETOK = 0;
               end
            end
         end
      end
   end

   // Record the length of every START_EN pulse in clk cycles.
   initial begin : sen_mon
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         if (D2A_TS_START_EN) c++;
         else if (c > 0) begin sen_q.push_back(c); c = 0; end
      end
   end

   task automatic wait_valid(input int budget, output bit got);
      got = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (ts_valid) begin got = 1; break; end
      end
   endtask

   task automatic settle;
      meas_en = 0; gen++;
      repeat (10) @(posedge clk);
      #1; gen++;
      plan_q.delete(); samp_q.delete(); chop_q.delete(); sen_q.delete();
      frame_no = 0; drop_frame = -1; A2D_TS_DETOK = 0;
   endtask

   task automatic test_reset;
      #12;
      n_chk++; if ({D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid, ts_err} !== 5'b0)
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid, ts_err}); else n_pass++;
      n_chk++; if (ts_out !== 8'h00) $display("FAIL reset_out: got %h expected 00", ts_out); else n_pass++;
      n_chk++; if (D2A_TS_EN !== 1'b1) $display("FAIL reset_en_tied: got %b expected 1", D2A_TS_EN); else n_pass++;
      RSTn = 1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      bit got; int s[$]; int off;
      settle();
      off = 3; reg_offset = OFS_W'(off);
      plan_q = '{'h70, 'h72, 'h6E, 'h70};
      meas_en = 1;
      wait_valid(3000, got);
      n_chk++; if (!got) $display("FAIL basic_valid: got no strobe expected strobe"); else n_pass++;
      for (int i = 0; i < NS && i < samp_q.size(); i++) s.push_back(samp_q[i]);
      exp_out = model(s, off);
      n_chk++; if (ts_out !== DW'(exp_out)) $display("FAIL basic_out: got %h expected %h", ts_out, exp_out); else n_pass++;
      for (int i = 0; i < NS; i++) begin
         n_chk++;
         if (i >= chop_q.size() || chop_q[i] !== 1'(i % 2))
            $display("FAIL basic_chop%0d: got %b expected %0d", i, (i < chop_q.size()) ? chop_q[i] : 1'bx, i % 2);
         else n_pass++;
         n_chk++;
         if (i >= sen_q.size() || sen_q[i] != CLK_DIV)
            $display("FAIL basic_start_len%0d: got %0d expected %0d", i, (i < sen_q.size()) ? sen_q[i] : -1, CLK_DIV);
         else n_pass++;
      end
      @(posedge clk); #1;
      n_chk++; if (ts_valid !== 1'b0) $display("FAIL basic_strobe_len: got %b expected 0", ts_valid); else n_pass++;
   endtask

   task automatic test_saturation;
      bit got; int s[$]; int offs[2]; int vals[2];
      offs[0] = 7; vals[0] = 'hFE; offs[1] = -8; vals[1] = 'h02;
      for (int k = 0; k < 2; k++) begin
         settle(); s.delete();
         reg_offset = OFS_W'(offs[k]);
         for (int i = 0; i < NS; i++) plan_q.push_back(vals[k]);
         meas_en = 1;
         wait_valid(3000, got);
         for (int i = 0; i < NS && i < samp_q.size(); i++) s.push_back(samp_q[i]);
         exp_out = model(s, offs[k]);
         n_chk++;
         if (!got || ts_out !== DW'(exp_out))
            $display("FAIL sat%0d: got %h (strobe %b) expected %h", k, ts_out, got, exp_out);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      bit got; int s[$]; int off;
      settle();
      off = $urandom_range(0, 15) - 8; reg_offset = OFS_W'(off);
      for (int i = 0; i < 2 * NS; i++) plan_q.push_back($urandom_range(0, 255));
      meas_en = 1;
      for (int m = 0; m < 2; m++) begin
         wait_valid(3000, got);
         s.delete();
         for (int i = m * NS; i < (m + 1) * NS && i < samp_q.size(); i++) s.push_back(samp_q[i]);
         exp_out = model(s, off);
         n_chk++;
         if (!got || ts_out !== DW'(exp_out))
            $display("FAIL b2b_out%0d: got %h (strobe %b) expected %h", m, ts_out, got, exp_out);
         else n_pass++;
      end
      n_chk++;
      if (chop_q.size() <= NS || chop_q[NS] !== 1'b0)
         $display("FAIL b2b_chop_restart: got %0d entries expected chopper 0 at sample %0d", chop_q.size(), NS);
      else n_pass++;
   endtask

   task automatic test_timeout;
      bit got; int s[$]; int off;
      settle();
      off = 2; reg_offset = OFS_W'(off);
      drop_frame = 1;
      for (int i = 0; i < NS; i++) plan_q.push_back($urandom_range(0, 255));
      meas_en = 1;
      wait_valid(4000, got);
      for (int i = 0; i < NS && i < samp_q.size(); i++) s.push_back(samp_q[i]);
      exp_out = model(s, off);
      n_chk++; if (!got || ts_out !== DW'(exp_out))
         $display("FAIL tmo_out: got %h (strobe %b) expected %h", ts_out, got, exp_out); else n_pass++;
      n_chk++; if (ts_err !== 1'b1) $display("FAIL tmo_err: got %b expected 1", ts_err); else n_pass++;
      n_chk++; if (samp_q.size() != NS) $display("FAIL tmo_count: got %0d samples expected %0d", samp_q.size(), NS); else n_pass++;
      for (int i = 0; i < NS; i++) begin
         n_chk++;
         if (i >= chop_q.size() || chop_q[i] !== 1'(i % 2))
            $display("FAIL tmo_chop%0d: got %b expected %0d", i, (i < chop_q.size()) ? chop_q[i] : 1'bx, i % 2);
         else n_pass++;
      end
   endtask

   task automatic test_single_shot;
      bit got; int s[$]; int off; int extra;
      settle();
      single_shot = 1; off = -3; reg_offset = OFS_W'(off);
      meas_en = 1;
      repeat (3) @(posedge clk); #1;
      n_chk++; if (ts_err !== 1'b0) $display("FAIL ss_err_clear: got %b expected 0", ts_err); else n_pass++;
      wait_valid(3000, got);
      for (int i = 0; i < NS && i < samp_q.size(); i++) s.push_back(samp_q[i]);
      exp_out = model(s, off);
      n_chk++; if (!got || ts_out !== DW'(exp_out))
         $display("FAIL ss_out1: got %h (strobe %b) expected %h", ts_out, got, exp_out); else n_pass++;
      extra = 0;
      for (int i = 0; i < 400; i++) begin @(posedge clk); #1; if (ts_valid) extra++; end
      n_chk++; if (extra != 0) $display("FAIL ss_extra_valid: got %0d expected 0", extra); else n_pass++;
      n_chk++; if ({D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK} !== 3'b0)
         $display("FAIL ss_idle_out: got %b expected 000", {D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK}); else n_pass++;
      meas_en = 0; repeat (3) @(posedge clk); #1;
      samp_q.delete(); chop_q.delete(); s.delete();
      meas_en = 1;
      wait_valid(3000, got);
      for (int i = 0; i < NS && i < samp_q.size(); i++) s.push_back(samp_q[i]);
      exp_out = model(s, off);
      n_chk++; if (!got || ts_out !== DW'(exp_out))
         $display("FAIL ss_out2: got %h (strobe %b) expected %h", ts_out, got, exp_out); else n_pass++;
      single_shot = 0;
   endtask

   task automatic test_drop;
      bit got; int s[$]; int off; int n;
      settle();
      off = 1; reg_offset = OFS_W'(off);
      meas_en = 1;
      n = 0;
      while (frame_no < 3 && n < 3000) begin @(posedge clk); n++; end
      n_chk++; if (frame_no < 3) $display("FAIL drop_reach_conv3: got %0d frames expected 3", frame_no); else n_pass++;
      repeat (10) @(posedge clk);
      #1 meas_en = 0; gen++;
      @(posedge clk); #1;
      n_chk++; if ({D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid} !== 4'b0)
         $display("FAIL drop_outputs: got %b expected 0000",
                  {D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid}); else n_pass++;
      n_chk++; if (ts_out !== DW'(exp_out)) $display("FAIL drop_ts_out_kept: got %h expected %h", ts_out, exp_out); else n_pass++;
      repeat (4) @(posedge clk); #1;
      samp_q.delete(); chop_q.delete();
      meas_en = 1;
      wait_valid(3000, got);
      for (int i = 0; i < NS && i < samp_q.size(); i++) s.push_back(samp_q[i]);
      exp_out = model(s, off);
      n_chk++; if (!got || ts_out !== DW'(exp_out))
         $display("FAIL drop_fresh_out: got %h (strobe %b) expected %h", ts_out, got, exp_out); else n_pass++;
      n_chk++; if (chop_q.size() == 0 || chop_q[0] !== 1'b0)
         $display("FAIL drop_fresh_chop: got %0d entries expected first chopper 0", chop_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int n;
      settle();
      meas_en = 1;
      n = 0;
      while (frame_no < 1 && n < 200) begin @(posedge clk); n++; end
      repeat (70) @(posedge clk);
      #3 RSTn = 0;
      #1;
      n_chk++; if ({D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid, ts_err} !== 5'b0 || ts_out !== 8'h00)
         $display("FAIL rstmid_outputs: got %b/%h expected 00000/00",
                  {D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid, ts_err}, ts_out); else n_pass++;
      reg_ts_en_sel = 1;
      for (int i = 0; i < 4; i++) begin
         FLOCK = ~FLOCK; A2D_TS_DETOK = ~A2D_TS_DETOK;
         @(posedge clk); #1;
         n_chk++; if (D2A_TS_EN !== FLOCK) $display("FAIL rst_en_track%0d: got %b expected %b", i, D2A_TS_EN, FLOCK); else n_pass++;
      end
      n_chk++; if ({D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid} !== 4'b0)
         $display("FAIL rst_hold_outputs: got %b expected 0000",
                  {D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, ts_valid}); else n_pass++;
      meas_en = 0; A2D_TS_DETOK = 0;
      RSTn = 1; reg_ts_en_sel = 0;
      repeat (3) @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_back_to_back();
      test_timeout();
      test_single_shot();
      test_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ts_ctrl_avg.md
Name: ts_ctrl_avg

Overview:
Parametrised next-generation temperature-sensor controller, fully synchronous to clk (no gated or derived clocks in the datapath). Generates the analog TS timing (enable, start pulse, conversion clock, chopper clock). Captures chopped ADC samples on the synchronised DETOK edge and averages 2^(AVG_LOG2+1) samples (equal numbers of chop-0 and chop-1). Produces an offset-corrected, saturated temperature code with a valid strobe. Supports continuous and single-shot modes and conversion timeout detection.

Parameters:
DW, 8, ADC data width (A2D_TS_DOUT, ts_out)
OFS_W, 4, width of signed offset trim
CLK_DIV, 25, clk cycles per tick (TS_CLK half-period); must be >=2
AVG_LOG2, 1, log2 of chop pairs per measurement (samples = 2^(AVG_LOG2+1))
TIMEOUT_TICKS, 40, ticks allowed in CONV before timeout

Ports:
clk  in  1  system clock (osc 16 MHz)
RSTn  in  1  asynchronous active-low reset
meas_en  in  1  measurement enable (level)
single_shot  in  1  1 = one measurement per meas_en rising edge; 0 = continuous
FLOCK  in  1  PLL lock
reg_ts_en_sel  in  1  1 = D2A_TS_EN follows FLOCK; 0 = tied high
reg_offset  in  OFS_W  signed two's-complement trim added to result
A2D_TS_DETOK  in  1  conversion done (asynchronous)
A2D_TS_DOUT  in  DW  conversion result, stable while DETOK high
D2A_TS_EN  out  1  analog enable
D2A_TS_START_EN  out  1  conversion start
D2A_TS_CLK  out  1  conversion clock
D2A_TS_CHOPPER_CLK  out  1  chopper phase
ts_out  out  DW  averaged corrected code
ts_valid  out  1  one-clk strobe on ts_out update
ts_err  out  1  sticky timeout flag

Behaviour:
- Reset RSTn is asynchronous, active-low; clock is clk. On reset: all outputs 0 except D2A_TS_EN (combinational); ts_out=0, ts_err=0; FSM=IDLE; accumulator, sample count, divider cleared.
- D2A_TS_EN = reg_ts_en_sel ? FLOCK : 1 (combinational, not gated by FSM).
- Tick: divider counts 0..CLK_DIV-1; tick when count==CLK_DIV-1. Divider is forced to 0 on every entry to START.
- DETOK: 2-flop synchroniser plus rising-edge detector. A detected edge samples A2D_TS_DOUT (unsynchronised, stable by protocol) into a capture register. Edge-to-capture latency is 3 clk.
- FSM states: IDLE, START, CONV, ACC, DONE.
- IDLE: all D2A outputs low except EN; chopper=0.
  - Exit to START when meas_en=1 (continuous), or on meas_en rising edge (single_shot).
- START: D2A_TS_START_EN=1 for exactly CLK_DIV clk cycles, D2A_TS_CLK=0. Then go to CONV with START_EN=0.
- CONV:
  - D2A_TS_CLK toggles on each tick.
  - Synchronised DETOK edge -> ACC.
  - TIMEOUT_TICKS ticks without an edge -> set ts_err, discard the frame, return to START with the same chopper phase and sample count unchanged.
- ACC (1 clk):
  - acc += capture; acc width DW+AVG_LOG2+1, no overflow possible.
  - Sample count +1; chopper toggles; TS_CLK forced 0.
  - If count reaches 2^(AVG_LOG2+1) -> DONE, else START.
- DONE (1 clk):
  - mean = acc >> (AVG_LOG2+1), truncating.
  - res = mean + sign_ext(reg_offset), saturated to [0, 2^DW-1].
  - ts_out <= res; ts_valid=1 for this cycle.
  - acc, count cleared; chopper = 0.
  - Next state: START if continuous and meas_en=1, else IDLE.
- Chopper is 0 for the first sample of every measurement and alternates per accepted sample; timed-out frames do not toggle it.
- meas_en=0 in any non-IDLE state: IDLE on next clk. Partial accumulation is discarded, D2A outputs go low, and ts_out/ts_err are retained. DONE has priority if meas_en falls in the same cycle.
- DETOK edge outside CONV: ignored.
- ts_err clears only on RSTn, or on a meas_en rising edge while in IDLE.
- reg_offset is sampled only in DONE.

Test Plan:
- Defaults, continuous, offset=+3, DOUT per frame 0x70,0x72,0x6E,0x70 -> chopper sequence 0,1,0,1; acc=448; one ts_valid pulse with ts_out=0x73; START_EN high exactly 25 clk per frame.
- All samples 0xFE, offset=+7 -> ts_out=0xFF (saturated high). All samples 0x02, offset=-8 (4'b1000) -> ts_out=0x00.
- DETOK held low in the 2nd frame -> ts_err=1 after 40 ticks in CONV; next START keeps chopper=1; after 4 good samples, ts_valid with correct mean; ts_err stays 1.
- single_shot=1, meas_en held high -> exactly one ts_valid, then IDLE with outputs low; lowering and raising meas_en starts a second measurement.
- meas_en dropped during 3rd CONV -> IDLE next clk, D2A_TS_CLK/START_EN/CHOPPER=0, ts_out unchanged. Re-enable -> first sample uses chopper=0 and a fresh accumulator.
- RSTn asserted mid-CONV with DETOK pulsing -> all outputs 0 immediately; reg_ts_en_sel=1, FLOCK toggling -> D2A_TS_EN tracks FLOCK even in reset.
